lif_input_sched: RTL and testbench

LIF_INPUT_SCHED -- requirements
Module: lif_input_sched

---
 rtl/lif_input_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_lif_input_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_input_sched.sv
// ---------------------------------------------------------------------------
// lif_input_sched
//
// Input scheduler for a single leaky-integrate-and-fire neuron. Four synaptic
// requesters compete for the neuron's input port through a round-robin
// arbiter. The scheduler also:
//   - forwards threshold loads to the neuron,
//   - holds off input for a refractory period after the neuron spikes,
//   - optionally injects one recurrent self-input once the refractory
//     period has ended.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   req_valid[4]   per-requester spike request
//   req_wspike[12] per-requester weight, requester k uses bits [3k+2:3k]
//   req_ready[4]   per-requester grant (combinational, one-hot or zero)
//   cfg_thres[6]   threshold value to load
//   cfg_load       one-cycle pulse requesting a threshold load
//   refrac_len[4]  refractory length, sampled when a spike is seen
//   recc_en        enable recurrent self-input after refractory
//   recc_w[3]      recurrent spike weight
//   n_spike        spike output from the neuron
//   n_svalid       registered spike-valid to the neuron
//   n_wspike[3]    registered weighted spike to the neuron
//   n_recc         registered, marks a recurrent input
//   n_thres[6]     registered threshold to the neuron
//   n_thres_valid  registered one-cycle threshold-load strobe
//   sched_state[3] current FSM state code
//   grant_cnt[8]   saturating count of accepted requests
// ---------------------------------------------------------------------------
module lif_input_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [11:0] req_wspike,
    output logic [3:0]  req_ready,
    input  logic [5:0]  cfg_thres,
    input  logic        cfg_load,
    input  logic [3:0]  refrac_len,
    input  logic        recc_en,
    input  logic [2:0]  recc_w,
    input  logic        n_spike,
    output logic        n_svalid,
    output logic [2:0]  n_wspike,
    output logic        n_recc,
    output logic [5:0]  n_thres,
    output logic        n_thres_valid,
    output logic [2:0]  sched_state,
    output logic [7:0]  grant_cnt
);

    typedef enum logic [2:0] {
        ST_WAIT_CFG = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_REFR     = 3'd3,
        ST_RECC     = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        cfg_pend_q, cfg_pend_d;
    logic [5:0]  thres_pend_q, thres_pend_d;
    logic [7:0]  grant_cnt_q, grant_cnt_d;
    logic        n_svalid_q, n_svalid_d;
    logic [2:0]  n_wspike_q, n_wspike_d;
    logic        n_recc_q, n_recc_d;
    logic [5:0]  n_thres_q, n_thres_d;
    logic        n_thres_valid_q, n_thres_valid_d;

    // A load pulse arriving this very cycle counts as pending, so it wins
    // over a same-cycle spike and suppresses grants immediately.
    logic pend_eff;
    assign pend_eff = cfg_pend_q | cfg_load;

    // ---------------------------------------------------------------------
    // Round-robin arbiter: rotate the request vector so that rr_ptr sits at
    // position 0, pick the lowest set bit, then rotate the index back.
    // ---------------------------------------------------------------------
    logic [1:0] rot_idx    [4];
    logic [2:0] wspike_arr [4];
    logic [3:0] rot_valid;
    logic [1:0] grant_off;
    logic [1:0] grant_idx;
    logic       grant_en;
    logic       handshake;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign rot_idx[gi]    = rr_ptr_q + 2'(gi);
            assign rot_valid[gi]  = req_valid[rot_idx[gi]];
            assign wspike_arr[gi] = req_wspike[3*gi +: 3];
            assign req_ready[gi]  = grant_en && (grant_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        grant_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_valid[i]) begin
                grant_off = 2'(i);
            end
        end
    end

    assign grant_idx = rr_ptr_q + grant_off;
    assign grant_en  = rst_n && (state_q == ST_RUN) && !pend_eff
                       && !n_spike && (|req_valid);
    // req_ready only ever targets a valid requester, so any grant is a
    // completed handshake.
    assign handshake = |req_ready;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        rcnt_d          = rcnt_q;
        cfg_pend_d      = cfg_pend_q | cfg_load;
        thres_pend_d    = cfg_load ? cfg_thres : thres_pend_q;
        grant_cnt_d     = grant_cnt_q;
        n_svalid_d      = 1'b0;
        n_wspike_d      = n_wspike_q;
        n_recc_d        = 1'b0;
        n_thres_d       = n_thres_q;
        n_thres_valid_d = 1'b0;

        case (state_q)
            ST_WAIT_CFG: begin
                if (pend_eff) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                state_d         = ST_RUN;
                n_thres_d       = thres_pend_q;
                n_thres_valid_d = 1'b1;
                // A pulse in the LOAD cycle itself re-arms another load.
                cfg_pend_d      = cfg_load;
            end

            ST_RUN: begin
                if (pend_eff) begin
                    state_d = ST_LOAD;
                end else if (n_spike) begin
                    rcnt_d = refrac_len;
                    if (refrac_len != 4'd0) begin
                        state_d = ST_REFR;
                    end else if (recc_en) begin
                        state_d = ST_RECC;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (handshake) begin
                    rr_ptr_d    = grant_idx + 2'd1;
                    grant_cnt_d = (grant_cnt_q == 8'hFF) ? grant_cnt_q
                                                         : grant_cnt_q + 8'd1;
                    n_svalid_d  = 1'b1;
                    n_wspike_d  = wspike_arr[grant_idx];
                end
            end

            ST_REFR: begin
                rcnt_d = rcnt_q - 4'd1;
                // rcnt was loaded with the length on entry, so the cycle in
                // which it reads 1 is the last refractory cycle.
                if (rcnt_q <= 4'd1) begin
                    rcnt_d  = 4'd0;
                    state_d = recc_en ? ST_RECC : ST_RUN;
                end
            end

            ST_RECC: begin
                state_d    = ST_RUN;
                n_svalid_d = 1'b1;
                n_wspike_d = recc_w;
                n_recc_d   = 1'b1;
            end

            default: begin
                state_d = ST_WAIT_CFG;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_WAIT_CFG;
            rr_ptr_q        <= 2'd0;
            rcnt_q          <= 4'd0;
            cfg_pend_q      <= 1'b0;
            thres_pend_q    <= 6'd0;
            grant_cnt_q     <= 8'd0;
            n_svalid_q      <= 1'b0;
            n_wspike_q      <= 3'd0;
            n_recc_q        <= 1'b0;
            n_thres_q       <= 6'd0;
            n_thres_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            rcnt_q          <= rcnt_d;
            cfg_pend_q      <= cfg_pend_d;
            thres_pend_q    <= thres_pend_d;
            grant_cnt_q     <= grant_cnt_d;
            n_svalid_q      <= n_svalid_d;
            n_wspike_q      <= n_wspike_d;
            n_recc_q        <= n_recc_d;
            n_thres_q       <= n_thres_d;
            n_thres_valid_q <= n_thres_valid_d;
        end
    end

    assign n_svalid      = n_svalid_q;
    assign n_wspike      = n_wspike_q;
    assign n_recc        = n_recc_q;
    assign n_thres       = n_thres_q;
    assign n_thres_valid = n_thres_valid_q;
    assign sched_state   = state_q;
    assign grant_cnt     = grant_cnt_q;

endmodule

// File: tb/tb_lif_input_sched.sv
// ---------------------------------------------------------------------------
// tb_lif_input_sched
//
// Self-checking bench for lif_input_sched. A directed table covers reset,
// threshold load and round-robin order; short hand-written sequences cover
// refractory/recurrent timing, spike-vs-load priority, counter saturation and
// reset mid-refractory; a randomized phase is checked cycle by cycle against
// a behavioural model of the scheduler's rules.
// ---------------------------------------------------------------------------
module tb_lif_input_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_wspike;
    logic [3:0]  req_ready;
    logic [5:0]  cfg_thres;
    logic        cfg_load;
    logic [3:0]  refrac_len;
    logic        recc_en;
    logic [2:0]  recc_w;
    logic        n_spike;
    logic        n_svalid;
    logic [2:0]  n_wspike;
    logic        n_recc;
    logic [5:0]  n_thres;
    logic        n_thres_valid;
    logic [2:0]  sched_state;
    logic [7:0]  grant_cnt;

    int n_checks = 0;
    int n_err    = 0;

    lif_input_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_wspike    (req_wspike),
        .req_ready     (req_ready),
        .cfg_thres     (cfg_thres),
        .cfg_load      (cfg_load),
        .refrac_len    (refrac_len),
        .recc_en       (recc_en),
        .recc_w        (recc_w),
        .n_spike       (n_spike),
        .n_svalid      (n_svalid),
        .n_wspike      (n_wspike),
        .n_recc        (n_recc),
        .n_thres       (n_thres),
        .n_thres_valid (n_thres_valid),
        .sched_state   (sched_state),
        .grant_cnt     (grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------------------------------------------------------------
    // Behavioural model. Modes use the published state codes as integers;
    // the refractory phase is tracked as "cycles still to spend".
    // ---------------------------------------------------------------------
    int   m_mode      = 0;
    int   m_rr        = 0;
    int   m_refr_left = 0;
    bit   m_pend      = 0;
    int   m_tpend     = 0;
    int   m_gcnt      = 0;
    int   m_sv        = 0;
    int   m_ws        = 0;
    int   m_rc        = 0;
    int   m_th        = 0;
    int   m_thv       = 0;

    // Requester the scheduler should grant this cycle, or -1 for none.
    function automatic int model_grant();
        int k;
        if (rst_n !== 1'b1 || m_mode != 2 || m_pend || cfg_load || n_spike)
            return -1;
        for (int i = 0; i < 4; i++) begin
            k = (m_rr + i) % 4;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input int g);
        bit load_now;
        bit pend_before;
        if (rst_n !== 1'b1) begin
            m_mode = 0; m_rr = 0; m_refr_left = 0; m_pend = 0; m_tpend = 0;
            m_gcnt = 0; m_sv = 0; m_ws = 0; m_rc = 0; m_th = 0; m_thv = 0;
            return;
        end
        load_now    = (cfg_load === 1'b1);
        pend_before = m_pend;
        m_sv  = 0;
        m_rc  = 0;
        m_thv = 0;
        if (m_mode == 0) begin
            if (pend_before || load_now) m_mode = 1;
        end else if (m_mode == 1) begin
            m_th  = m_tpend;
            m_thv = 1;
            m_mode = 2;
            pend_before = 0;
        end else if (m_mode == 2) begin
            if (pend_before || load_now) begin
                m_mode = 1;
            end else if (n_spike) begin
                m_refr_left = int'(refrac_len);
                if (m_refr_left > 0) m_mode = 3;
                else                 m_mode = recc_en ? 4 : 2;
            end else if (g >= 0) begin
                m_rr   = (g + 1) % 4;
                m_gcnt = (m_gcnt >= 255) ? 255 : m_gcnt + 1;
                m_sv   = 1;
                m_ws   = int'(req_wspike[3*g +: 3]);
            end
        end else if (m_mode == 3) begin
            m_refr_left = m_refr_left - 1;
            if (m_refr_left == 0) m_mode = recc_en ? 4 : 2;
        end else begin
            m_mode = 2;
            m_sv   = 1;
            m_ws   = int'(recc_w);
            m_rc   = 1;
        end
        m_pend = pend_before || load_now;
        if (load_now) m_tpend = int'(cfg_thres);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle with inputs already applied. Checks the combinational
    // grant before the edge and all registered outputs just after it.
    task automatic tick(input bit use_tab, input logic [3:0] t_ready, input logic [2:0] t_state);
        int g;
        logic [3:0] er;
        #3;
        g  = model_grant();
        er = (g < 0) ? 4'd0 : 4'(1 << g);
        chk("req_ready", 16'(req_ready), 16'(er));
        if (use_tab) chk("tab_ready", 16'(req_ready), 16'(t_ready));
        if (g >= 0) $display("txn t=%0t grant=%0d w=%0d", $time, g, req_wspike[3*g +: 3]);
        @(posedge clk);
        model_step(g);
        #1;
        chk("sched_state",   16'(sched_state),   16'(m_mode));
        chk("n_svalid",      16'(n_svalid),      16'(m_sv));
        chk("n_wspike",      16'(n_wspike),      16'(m_ws));
        chk("n_recc",        16'(n_recc),        16'(m_rc));
        chk("n_thres",       16'(n_thres),       16'(m_th));
        chk("n_thres_valid", 16'(n_thres_valid), 16'(m_thv));
        chk("grant_cnt",     16'(grant_cnt),     16'(m_gcnt));
        if (use_tab) chk("tab_state", 16'(sched_state), 16'(t_state));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       ld;
        logic       sp;
        logic [3:0] exp_ready;
        logic [2:0] exp_state;
    } vec_t;

    vec_t tab [11];

    initial begin
        tab[0]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'b0000, 3'd0};
        tab[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b0000, 3'd0};
        tab[2]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b0000, 3'd0};
        tab[3]  = '{1'b1, 4'hF, 1'b1, 1'b0, 4'b0000, 3'd1};
        tab[4]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b0000, 3'd2};
        tab[5]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b0001, 3'd2};
        tab[6]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b0010, 3'd2};
        tab[7]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b0100, 3'd2};
        tab[8]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b1000, 3'd2};
        tab[9]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'b0001, 3'd2};
        tab[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 4'b0000, 3'd2};

        rst_n      = 1'b0;
        req_valid  = 4'h0;
        req_wspike = {3'd4, 3'd3, 3'd2, 3'd1};
        cfg_thres  = 6'd20;
        cfg_load   = 1'b0;
        refrac_len = 4'd0;
        recc_en    = 1'b0;
        recc_w     = 3'd0;
        n_spike    = 1'b0;

        // Reset, idle without config, load threshold 20, round-robin grants.
        for (int i = 0; i < 11; i++) begin
            rst_n     = tab[i].rst;
            req_valid = tab[i].valid;
            cfg_load  = tab[i].ld;
            n_spike   = tab[i].sp;
            tick(1'b1, tab[i].exp_ready, tab[i].exp_state);
            if (i == 4) begin
                chk("load_thres",  16'(n_thres), 16'd20);
                chk("load_strobe", 16'(n_thres_valid), 16'd1);
            end
            if (i == 5) chk("strobe_one_cycle", 16'(n_thres_valid), 16'd0);
        end
        chk("rr_grant_cnt", 16'(grant_cnt), 16'd5);
        chk("wspike_hold",  16'(n_wspike),  16'd1);
        chk("svalid_idle",  16'(n_svalid),  16'd0);

        // Spike in RUN: 3 refractory cycles, one recurrent cycle, then RUN.
        refrac_len = 4'd3; recc_en = 1'b1; recc_w = 3'd5;
        req_valid  = 4'hF; n_spike = 1'b1;
        tick(1'b1, 4'b0000, 3'd3);
        n_spike = 1'b0;
        tick(1'b1, 4'b0000, 3'd3);
        tick(1'b1, 4'b0000, 3'd3);
        tick(1'b1, 4'b0000, 3'd4);
        tick(1'b1, 4'b0000, 3'd2);
        chk("recc_svalid", 16'(n_svalid), 16'd1);
        chk("recc_wspike", 16'(n_wspike), 16'd5);
        chk("recc_flag",   16'(n_recc),   16'd1);
        tick(1'b1, 4'b0010, 3'd2);

        // Spike and load together: load wins, spike dropped.
        cfg_thres = 6'd33; cfg_load = 1'b1; n_spike = 1'b1;
        tick(1'b1, 4'b0000, 3'd1);
        cfg_load = 1'b0; n_spike = 1'b0;
        tick(1'b1, 4'b0000, 3'd2);
        chk("prio_thres", 16'(n_thres), 16'd33);

        // Saturation of the grant counter.
        req_valid = 4'hF;
        for (int i = 0; i < 300; i++) tick(1'b0, 4'b0000, 3'd0);
        chk("grant_sat", 16'(grant_cnt), 16'd255);

        // Move rr_ptr away from 0, enter REFR, then reset mid-refractory.
        req_valid = 4'b0100;
        tick(1'b1, 4'b0100, 3'd2);
        req_valid = 4'hF; n_spike = 1'b1;
        tick(1'b1, 4'b0000, 3'd3);
        n_spike = 1'b0;
        tick(1'b1, 4'b0000, 3'd3);
        rst_n = 1'b0;
        tick(1'b1, 4'b0000, 3'd0);
        chk("rst_svalid", 16'(n_svalid),      16'd0);
        chk("rst_wspike", 16'(n_wspike),      16'd0);
        chk("rst_recc",   16'(n_recc),        16'd0);
        chk("rst_thres",  16'(n_thres),       16'd0);
        chk("rst_thv",    16'(n_thres_valid), 16'd0);
        chk("rst_gcnt",   16'(grant_cnt),     16'd0);
        rst_n = 1'b1; cfg_thres = 6'd7; cfg_load = 1'b1;
        tick(1'b1, 4'b0000, 3'd1);
        cfg_load = 1'b0;
        tick(1'b1, 4'b0000, 3'd2);
        tick(1'b1, 4'b0001, 3'd2);

        // Randomized phase against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            req_valid  = 4'($urandom);
            req_wspike = 12'($urandom);
            cfg_thres  = 6'($urandom);
            cfg_load   = ($urandom_range(0, 11) == 0);
            refrac_len = 4'($urandom_range(0, 4));
            recc_en    = 1'($urandom);
            recc_w     = 3'($urandom);
            n_spike    = ($urandom_range(0, 7) == 0);
            tick(1'b0, 4'b0000, 3'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
